layer_compositor: RTL

Parametrised per-pixel compositor and game-state engine for the VGA path. It sits between the sprite/maze/dot lookups and the VGA DAC. It resolves N ghost layers, Pac, dots, walls and end screens by priority with transparency, and registers RGB with one cycle of latency. It also owns dot liveness, score, lives and a frame-synchronous PLAY/HIT/WIN/OVER state machine, so each dot eaten and each ghost collision counts exactly once.

---
 rtl/layer_pkg.sv | 30 +++
 rtl/ghost_priority_mux.sv | 33 +++
 rtl/layer_compositor.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/layer_pkg.sv
// layer_pkg
// Shared types and constants for the layer compositor.
//   game_state_t : PLAY / HIT / WIN / OVER encoding, which is also the
//                  game_state port value
//   *_RGB        : fixed colours for dots, walls, end screens and background
//   TRANSPARENT_DEFAULT : sprite colour that means "not drawn"
package layer_pkg;

    typedef enum logic [1:0] {
        ST_PLAY = 2'd0,
        ST_HIT  = 2'd1,
        ST_WIN  = 2'd2,
        ST_OVER = 2'd3
    } game_state_t;

    localparam logic [23:0] DOT_RGB             = 24'h00FFAA;
    localparam logic [23:0] WALL_RGB            = 24'h1F2BDB;
    localparam logic [23:0] WIN_RGB             = 24'h00FF00;
    localparam logic [23:0] OVER_RGB            = 24'h0000FF;
    localparam logic [23:0] BG_RGB              = 24'h000000;
    localparam logic [23:0] TRANSPARENT_DEFAULT = 24'h000000;

    // A layer is drawn only when it claims the pixel and its colour is not the
    // transparent key.
    function automatic logic layer_opaque(input logic hit, input logic [23:0] rgb,
                                          input logic [23:0] transparent);
        return hit && (rgb != transparent);
    endfunction

endpackage

// File: rtl/ghost_priority_mux.sv
// ghost_priority_mux
// Resolves overlapping ghost sprites: the lowest-index opaque ghost wins.
// Ports:
//   is_ghost   in  NUM_GHOSTS     per-ghost hit at this pixel
//   ghost_rgb  in  24*NUM_GHOSTS  per-ghost colour, ghost 0 in [23:0]
//   any_opaque out 1              at least one ghost is drawn here
//   sel_rgb    out 24             colour of the winning ghost (BG if none)
module ghost_priority_mux
    import layer_pkg::*;
#(
    parameter int          NUM_GHOSTS  = 4,
    parameter logic [23:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic [NUM_GHOSTS-1:0]    is_ghost,
    input  logic [24*NUM_GHOSTS-1:0] ghost_rgb,
    output logic                     any_opaque,
    output logic [23:0]              sel_rgb
);

    // Scan from the highest index down so the lowest opaque index is the
    // last assignment and therefore the winner.
    always_comb begin
        any_opaque = 1'b0;
        sel_rgb    = BG_RGB;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (layer_opaque(is_ghost[i], ghost_rgb[i*24 +: 24], TRANSPARENT)) begin
                any_opaque = 1'b1;
                sel_rgb    = ghost_rgb[i*24 +: 24];
            end
        end
    end

endmodule

// File: rtl/layer_compositor.sv
// layer_compositor
// Per-pixel layer compositor plus game-state engine for the VGA path.
// Colour is resolved by priority (end screen, ghosts, Pac, live dot, wall)
// and registered with one cycle of latency. Dot liveness, score, lives and
// the PLAY/HIT/WIN/OVER machine are also kept here so each dot eaten and
// each collision counts exactly once.
// Ports:
//   Clk, Reset_n              pixel clock, async active-low reset
//   frame_start               one-cycle pulse at start of frame
//   pix_valid, DrawX, DrawY   current pixel and active-video flag
//   is_wall                   maze wall at pixel
//   is_pac, pac_rgb           Pac layer
//   is_ghost, ghost_rgb       ghost layers, ghost 0 in [23:0]
//   is_dot, dot_idx           dot region and index
//   is_end_font               end-screen glyph pixel
//   restart                   honoured only in WIN/OVER
//   VGA_R/G/B, rgb_valid      registered colour and registered pix_valid
//   alive, score, lives       game counters
//   game_state, pac_hit       state and one-cycle hit-accepted pulse
//
// state   | meaning
// --------+--------------------------------------------------------
// PLAY    | normal play; dots can be eaten, collisions recorded
// HIT     | frozen for HIT_FRAMES frames after a hit, Pac blinks
// WIN     | all dots eaten; end screen, waits for restart
// OVER    | out of lives; end screen, waits for restart
module layer_compositor
    import layer_pkg::*;
#(
    parameter int          NUM_GHOSTS  = 4,
    parameter int          NUM_DOTS    = 10,
    parameter int          DOT_W       = $clog2(NUM_DOTS),
    parameter int          SCORE_W     = 8,
    parameter int          LIVES       = 3,
    parameter int          HIT_FRAMES  = 60,
    parameter logic [23:0] TRANSPARENT = TRANSPARENT_DEFAULT
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic                     frame_start,
    input  logic                     pix_valid,
    input  logic [9:0]               DrawX,
    input  logic [9:0]               DrawY,
    input  logic                     is_wall,
    input  logic                     is_pac,
    input  logic [23:0]              pac_rgb,
    input  logic [NUM_GHOSTS-1:0]    is_ghost,
    input  logic [24*NUM_GHOSTS-1:0] ghost_rgb,
    input  logic                     is_dot,
    input  logic [DOT_W-1:0]         dot_idx,
    input  logic                     is_end_font,
    input  logic                     restart,
    output logic [7:0]               VGA_R,
    output logic [7:0]               VGA_G,
    output logic [7:0]               VGA_B,
    output logic                     rgb_valid,
    output logic [NUM_DOTS-1:0]      alive,
    output logic [SCORE_W-1:0]       score,
    output logic [2:0]               lives,
    output logic [1:0]               game_state,
    output logic                     pac_hit
);

    localparam int              HOLD_W     = $clog2(HIT_FRAMES + 1);
    localparam logic [2:0]      LIVES_INIT = 3'(LIVES);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HIT_FRAMES);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    game_state_t         state_q, state_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic [2:0]          lives_q, lives_d;
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [NUM_DOTS-1:0] alive_q, alive_d;
    logic                hit_flag_q, hit_flag_d;
    logic                pac_hit_q, pac_hit_d;
    logic [3:0]          frame_cnt_q, frame_cnt_d;
    logic [23:0]         rgb_q, rgb_d;
    logic                rgb_valid_q;

    logic                ghost_any;
    logic [23:0]         ghost_sel_rgb;
    logic                pac_opaque;
    logic                pac_shown;
    logic                dot_live;
    logic                eat;
    logic                collide;

    // Pixel position is already folded into the upstream layer lookups.
    logic                unused_draw;
    assign unused_draw = ^{DrawX, DrawY};

    ghost_priority_mux #(
        .NUM_GHOSTS  (NUM_GHOSTS),
        .TRANSPARENT (TRANSPARENT)
    ) u_ghost_mux (
        .is_ghost   (is_ghost),
        .ghost_rgb  (ghost_rgb),
        .any_opaque (ghost_any),
        .sel_rgb    (ghost_sel_rgb)
    );

    assign pac_opaque = layer_opaque(is_pac, pac_rgb, TRANSPARENT);
    assign pac_shown  = pac_opaque && !((state_q == ST_HIT) && frame_cnt_q[3]);

    // Out-of-range indices match no loop iteration, so they read as dead.
    always_comb begin
        dot_live = 1'b0;
        for (int i = 0; i < NUM_DOTS; i++) begin
            if (dot_idx == DOT_W'(i)) begin
                dot_live = alive_q[i];
            end
        end
    end

    assign eat     = (state_q == ST_PLAY) && pix_valid && is_dot && dot_live && pac_opaque;
    assign collide = (state_q == ST_PLAY) && pix_valid && pac_opaque && ghost_any;

    // Colour uses the pre-update alive vector, so the eating pixel still
    // shows Pac (which outranks the dot anyway).
    always_comb begin
        rgb_d = BG_RGB;
        if (pix_valid) begin
            if (state_q == ST_WIN) begin
                rgb_d = is_end_font ? WIN_RGB : BG_RGB;
            end else if (state_q == ST_OVER) begin
                rgb_d = is_end_font ? OVER_RGB : BG_RGB;
            end else if (ghost_any) begin
                rgb_d = ghost_sel_rgb;
            end else if (pac_shown) begin
                rgb_d = pac_rgb;
            end else if (is_dot && dot_live) begin
                rgb_d = DOT_RGB;
            end else if (is_wall) begin
                rgb_d = WALL_RGB;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= ST_PLAY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and game counters. The frame_start decision looks at the
    // hit_flag and alive values from before this cycle; the coincident pixel
    // belongs to the new frame and seeds the new hit_flag.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        lives_d     = lives_q;
        score_d     = score_q;
        alive_d     = alive_q;
        hit_flag_d  = hit_flag_q | collide;
        pac_hit_d   = 1'b0;
        frame_cnt_d = frame_cnt_q + {3'b000, frame_start};

        if (eat) begin
            for (int i = 0; i < NUM_DOTS; i++) begin
                if (dot_idx == DOT_W'(i)) begin
                    alive_d[i] = 1'b0;
                end
            end
            if (score_q != SCORE_MAX) begin
                score_d = score_q + SCORE_W'(1);
            end
        end

        if (restart && ((state_q == ST_WIN) || (state_q == ST_OVER))) begin
            alive_d    = '1;
            score_d    = '0;
            lives_d    = LIVES_INIT;
            hit_flag_d = 1'b0;
            state_d    = ST_PLAY;
        end else if (frame_start) begin
            hit_flag_d = collide;
            unique case (state_q)
                ST_PLAY: begin
                    // Win outranks a same-frame hit; lives stay untouched.
                    if (alive_q == '0) begin
                        state_d = ST_WIN;
                    end else if (hit_flag_q) begin
                        lives_d   = lives_q - 3'd1;
                        pac_hit_d = 1'b1;
                        if (lives_q <= 3'd1) begin
                            state_d = ST_OVER;
                        end else begin
                            state_d = ST_HIT;
                            hold_d  = HOLD_INIT;
                        end
                    end
                end
                ST_HIT: begin
                    if (hold_q <= HOLD_W'(1)) begin
                        hold_d  = '0;
                        state_d = ST_PLAY;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hold_q      <= '0;
            lives_q     <= LIVES_INIT;
            score_q     <= '0;
            alive_q     <= '1;
            hit_flag_q  <= 1'b0;
            pac_hit_q   <= 1'b0;
            frame_cnt_q <= '0;
            rgb_q       <= BG_RGB;
            rgb_valid_q <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            alive_q     <= alive_d;
            hit_flag_q  <= hit_flag_d;
            pac_hit_q   <= pac_hit_d;
            frame_cnt_q <= frame_cnt_d;
            rgb_q       <= rgb_d;
            rgb_valid_q <= pix_valid;
        end
    end

    assign VGA_R      = rgb_q[23:16];
    assign VGA_G      = rgb_q[15:8];
    assign VGA_B      = rgb_q[7:0];
    assign rgb_valid  = rgb_valid_q;
    assign alive      = alive_q;
    assign score      = score_q;
    assign lives      = lives_q;
    assign game_state = state_q;
    assign pac_hit    = pac_hit_q;

endmodule
